// File: rtl/pcg_pkg.sv
// ----------------------------------------------------------------------------
// pcg_pkg
// Shared definitions for the fetch-stage program-counter generator.
//   - Default reset vector, exception vector and sequential increment.
//   - Next-PC source enumeration used by the priority mux in pc_gen.
// ----------------------------------------------------------------------------
package pcg_pkg;

    localparam logic [31:0] PCG_RESET_VEC   = 32'h0000_3000;
    localparam logic [31:0] PCG_EXC_VEC     = 32'h0000_4180;
    localparam int          PCG_INSTR_BYTES = 4;

    // Listed in decreasing priority order.
    typedef enum logic [2:0] {
        SRC_EXC   = 3'd0,
        SRC_ERET  = 3'd1,
        SRC_HOLD  = 3'd2,
        SRC_REDIR = 3'd3,
        SRC_RAS   = 3'd4,
        SRC_SEQ   = 3'd5
    } pcg_src_e;

endpackage

// File: rtl/pcg_ras.sv
// ----------------------------------------------------------------------------
// pcg_ras
// Circular return-address stack with a top pointer and a saturating count.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset (pointer, count, uflow only)
//   push_i   : push link_i (already qualified by the caller)
//   pop_i    : pop top entry (already qualified by the caller)
//   link_i   : return address to push
//   top_o    : current top entry (valid only when not empty)
//   empty_o  : count == 0
//   full_o   : count == RAS_DEPTH
//   uflow_o  : registered one-cycle pulse after a pop on an empty stack
// ----------------------------------------------------------------------------
module pcg_ras #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] link_i,
    output logic [WIDTH-1:0] top_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             uflow_o
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             uflow_q, uflow_d;
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == DEPTH_C);
    assign top_o   = mem_q[ptr_q];
    assign uflow_o = uflow_q;

    // Stack update. A simultaneous push and pop on a non-empty stack is a
    // replace of the top entry: pointer and count stay put. A push on a full
    // stack advances the pointer onto the oldest slot and overwrites it while
    // the count saturates. A pop on an empty stack only raises uflow.
    always_comb begin
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        uflow_d = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = ptr_q;
        if (push_i && pop_i && !empty_o) begin
            wr_en  = 1'b1;
            wr_idx = ptr_q;
        end else if (push_i) begin
            ptr_d   = ptr_q + 1'b1;
            wr_en   = 1'b1;
            wr_idx  = ptr_q + 1'b1;
            uflow_d = pop_i;
            if (!full_o) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (pop_i) begin
            if (!empty_o) begin
                ptr_d = ptr_q - 1'b1;
                cnt_d = cnt_q - 1'b1;
            end else begin
                uflow_d = 1'b1;
            end
        end
    end

    // Control state: reset clears pointer, count and the underflow pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            cnt_q   <= '0;
            uflow_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            uflow_q <= uflow_d;
        end
    end

    // Entry storage is deliberately not reset; entries are only read once
    // the count says they have been written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= link_i;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// ----------------------------------------------------------------------------
// pc_gen
// Fetch-stage program-counter generator with a return-address stack.
//   PCG_clk_F_i       : clock, rising edge
//   PCG_reset_n_F_i   : asynchronous active-low reset
//   PCG_stall_F_i     : hold PC
//   PCG_exc_F_i       : exception request (go to EXC_VEC)
//   PCG_eret_F_i      : exception return (go to PCG_epc_F_i)
//   PCG_epc_F_i       : eret target
//   PCG_redir_F_i     : taken branch/jump from decode
//   PCG_target_F_i    : redirect target
//   PCG_call_F_i      : push PCG_link_F_i onto the RAS
//   PCG_link_F_i      : return address to push
//   PCG_ret_F_i       : pop the RAS and redirect to the popped value
//   PCG_pc_F_o        : current fetch PC
//   PCG_misalign_F_o  : PC[1:0] != 0
//   PCG_ras_empty_F_o : RAS empty
//   PCG_ras_full_F_o  : RAS full
//   PCG_ras_uflow_F_o : one-cycle pulse after ret on an empty RAS
// ----------------------------------------------------------------------------
module pc_gen
    import pcg_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VEC   = WIDTH'(PCG_RESET_VEC),
    parameter logic [WIDTH-1:0] EXC_VEC     = WIDTH'(PCG_EXC_VEC),
    parameter int               INSTR_BYTES = PCG_INSTR_BYTES,
    parameter int               RAS_DEPTH   = 4
) (
    input  logic             PCG_clk_F_i,
    input  logic             PCG_reset_n_F_i,
    input  logic             PCG_stall_F_i,
    input  logic             PCG_exc_F_i,
    input  logic             PCG_eret_F_i,
    input  logic [WIDTH-1:0] PCG_epc_F_i,
    input  logic             PCG_redir_F_i,
    input  logic [WIDTH-1:0] PCG_target_F_i,
    input  logic             PCG_call_F_i,
    input  logic [WIDTH-1:0] PCG_link_F_i,
    input  logic             PCG_ret_F_i,
    output logic [WIDTH-1:0] PCG_pc_F_o,
    output logic             PCG_misalign_F_o,
    output logic             PCG_ras_empty_F_o,
    output logic             PCG_ras_full_F_o,
    output logic             PCG_ras_uflow_F_o
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] ras_top;
    logic             ras_empty;
    logic             accepted;
    pcg_src_e         src_sel;

    // Exceptions and eret pre-empt the stall; everything else waits for an
    // unstalled cycle and is re-presented by upstream until then.
    assign accepted = !PCG_stall_F_i && !PCG_exc_F_i && !PCG_eret_F_i;

    pcg_ras #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (PCG_clk_F_i),
        .rst_n   (PCG_reset_n_F_i),
        .push_i  (accepted && PCG_call_F_i),
        .pop_i   (accepted && PCG_ret_F_i),
        .link_i  (PCG_link_F_i),
        .top_o   (ras_top),
        .empty_o (ras_empty),
        .full_o  (PCG_ras_full_F_o),
        .uflow_o (PCG_ras_uflow_F_o)
    );

    // Fixed-priority next-PC selection. A ret on an empty RAS falls through
    // to the sequential path.
    always_comb begin
        src_sel = SRC_SEQ;
        if (PCG_exc_F_i) begin
            src_sel = SRC_EXC;
        end else if (PCG_eret_F_i) begin
            src_sel = SRC_ERET;
        end else if (PCG_stall_F_i) begin
            src_sel = SRC_HOLD;
        end else if (PCG_redir_F_i) begin
            src_sel = SRC_REDIR;
        end else if (PCG_ret_F_i && !ras_empty) begin
            src_sel = SRC_RAS;
        end

        pc_d = pc_q + WIDTH'(INSTR_BYTES);
        case (src_sel)
            SRC_EXC:   pc_d = EXC_VEC;
            SRC_ERET:  pc_d = PCG_epc_F_i;
            SRC_HOLD:  pc_d = pc_q;
            SRC_REDIR: pc_d = PCG_target_F_i;
            SRC_RAS:   pc_d = ras_top;
            default:   pc_d = pc_q + WIDTH'(INSTR_BYTES);
        endcase
    end

    // PC register.
    always_ff @(posedge PCG_clk_F_i or negedge PCG_reset_n_F_i) begin
        if (!PCG_reset_n_F_i) begin
            pc_q <= RESET_VEC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign PCG_pc_F_o        = pc_q;
    assign PCG_misalign_F_o  = (pc_q[1:0] != 2'b00);
    assign PCG_ras_empty_F_o = ras_empty;

endmodule

// File: tb/tb_pc_gen.sv
// ----------------------------------------------------------------------------
// tb_pc_gen
// Directed self-checking bench for pc_gen. Expected PC and flag values are
// queued when each step is driven and popped when the DUT output is sampled.
// ----------------------------------------------------------------------------
module tb_pc_gen;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        exc;
    logic        eret;
    logic [31:0] epc;
    logic        redir;
    logic [31:0] target;
    logic        call;
    logic [31:0] link;
    logic        ret;
    logic [31:0] pc;
    logic        misalign;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_uflow;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [3:0]  flags;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    pc_gen dut (
        .PCG_clk_F_i       (clk),
        .PCG_reset_n_F_i   (rst_n),
        .PCG_stall_F_i     (stall),
        .PCG_exc_F_i       (exc),
        .PCG_eret_F_i      (eret),
        .PCG_epc_F_i       (epc),
        .PCG_redir_F_i     (redir),
        .PCG_target_F_i    (target),
        .PCG_call_F_i      (call),
        .PCG_link_F_i      (link),
        .PCG_ret_F_i       (ret),
        .PCG_pc_F_o        (pc),
        .PCG_misalign_F_o  (misalign),
        .PCG_ras_empty_F_o (ras_empty),
        .PCG_ras_full_F_o  (ras_full),
        .PCG_ras_uflow_F_o (ras_uflow)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pops the oldest expectation and compares PC and the flag vector
    // {misalign, empty, full, uflow} against the DUT.
    task automatic checkOutput();
        exp_t       e;
        logic [3:0] got_flags;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard_empty observed=0 entries expected=1");
            return;
        end
        e = sb.pop_front();
        got_flags = {misalign, ras_empty, ras_full, ras_uflow};
        checks++;
        assert (pc === e.pc) else begin
            failures++;
            $error("[TB] FAIL %s_pc observed=%h expected=%h", e.tag, pc, e.pc);
        end
        checks++;
        assert (got_flags === e.flags) else begin
            failures++;
            $error("[TB] FAIL %s_flags(mis,emp,full,uf) observed=%b expected=%b",
                   e.tag, got_flags, e.flags);
        end
    endtask

    // Queues an expectation and checks it without waiting for a clock edge.
    task automatic checkNow(input string tag, input logic [31:0] exp_pc,
                            input logic exp_empty, input logic exp_full,
                            input logic exp_uflow);
        exp_t e;
        e.tag   = tag;
        e.pc    = exp_pc;
        e.flags = {(exp_pc[1:0] != 2'b00), exp_empty, exp_full, exp_uflow};
        sb.push_back(e);
        checkOutput();
    endtask

    // Inputs are already driven by the caller; queue the expectation for the
    // state after the next rising edge, sample 1 ns later, then idle inputs.
    task automatic applyStimulus(input string tag, input logic [31:0] exp_pc,
                                 input logic exp_empty, input logic exp_full,
                                 input logic exp_uflow);
        exp_t e;
        e.tag   = tag;
        e.pc    = exp_pc;
        e.flags = {(exp_pc[1:0] != 2'b00), exp_empty, exp_full, exp_uflow};
        sb.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
        stall = 1'b0;
        exc   = 1'b0;
        eret  = 1'b0;
        redir = 1'b0;
        call  = 1'b0;
        ret   = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b0;
        stall  = 1'b0;
        exc    = 1'b0;
        eret   = 1'b0;
        epc    = 32'h0;
        redir  = 1'b0;
        target = 32'h0;
        call   = 1'b0;
        link   = 32'h0;
        ret    = 1'b0;

        #12;
        checkNow("reset", 32'h3000, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;

        applyStimulus("seq1", 32'h3004, 1'b1, 1'b0, 1'b0);
        applyStimulus("seq2", 32'h3008, 1'b1, 1'b0, 1'b0);
        applyStimulus("seq3", 32'h300C, 1'b1, 1'b0, 1'b0);

        call = 1'b1; link = 32'h1234;
        applyStimulus("pre_reset_call", 32'h3010, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a cycle.
        rst_n = 1'b0;
        #1;
        checkNow("mid_reset", 32'h3000, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b1;

        stall = 1'b1; redir = 1'b1; target = 32'h3100;
        applyStimulus("stall_redir", 32'h3000, 1'b1, 1'b0, 1'b0);
        redir = 1'b1; target = 32'h3100;
        applyStimulus("redir", 32'h3100, 1'b1, 1'b0, 1'b0);
        stall = 1'b1; exc = 1'b1;
        applyStimulus("stall_exc", 32'h4180, 1'b1, 1'b0, 1'b0);
        exc = 1'b1; redir = 1'b1; eret = 1'b1; epc = 32'h3020; target = 32'h3100;
        applyStimulus("exc_prio", 32'h4180, 1'b1, 1'b0, 1'b0);
        eret = 1'b1; epc = 32'h3020;
        applyStimulus("eret", 32'h3020, 1'b1, 1'b0, 1'b0);

        call = 1'b1; link = 32'h3008;
        applyStimulus("call", 32'h3024, 1'b0, 1'b0, 1'b0);
        eret = 1'b1; epc = 32'h3030; ret = 1'b1;
        applyStimulus("eret_ignores_ret", 32'h3030, 1'b0, 1'b0, 1'b0);
        ret = 1'b1;
        applyStimulus("ret", 32'h3008, 1'b1, 1'b0, 1'b0);
        ret = 1'b1;
        applyStimulus("ret_empty", 32'h300C, 1'b1, 1'b0, 1'b1);
        applyStimulus("uflow_clear", 32'h3010, 1'b1, 1'b0, 1'b0);

        call = 1'b1; link = 32'h10;
        applyStimulus("push10", 32'h3014, 1'b0, 1'b0, 1'b0);
        call = 1'b1; link = 32'h20;
        applyStimulus("push20", 32'h3018, 1'b0, 1'b0, 1'b0);
        call = 1'b1; link = 32'h30;
        applyStimulus("push30", 32'h301C, 1'b0, 1'b0, 1'b0);
        call = 1'b1; link = 32'h40;
        applyStimulus("push40", 32'h3020, 1'b0, 1'b1, 1'b0);
        call = 1'b1; link = 32'h50;
        applyStimulus("push50_full", 32'h3024, 1'b0, 1'b1, 1'b0);
        ret = 1'b1;
        applyStimulus("pop50", 32'h50, 1'b0, 1'b0, 1'b0);
        ret = 1'b1;
        applyStimulus("pop40", 32'h40, 1'b0, 1'b0, 1'b0);
        ret = 1'b1;
        applyStimulus("pop30", 32'h30, 1'b0, 1'b0, 1'b0);
        ret = 1'b1;
        applyStimulus("pop20", 32'h20, 1'b1, 1'b0, 1'b0);
        ret = 1'b1;
        applyStimulus("pop_uflow", 32'h24, 1'b1, 1'b0, 1'b1);

        call = 1'b1; link = 32'h3040;
        applyStimulus("push3040", 32'h28, 1'b0, 1'b0, 1'b0);
        call = 1'b1; ret = 1'b1; link = 32'h3080;
        applyStimulus("call_ret", 32'h3040, 1'b0, 1'b0, 1'b0);
        ret = 1'b1;
        applyStimulus("ret_replaced", 32'h3080, 1'b1, 1'b0, 1'b0);

        redir = 1'b1; target = 32'h3102;
        applyStimulus("misalign", 32'h3102, 1'b1, 1'b0, 1'b0);
        applyStimulus("misalign_seq", 32'h3106, 1'b1, 1'b0, 1'b0);
        redir = 1'b1; target = 32'hFFFF_FFFC;
        applyStimulus("to_top", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
        applyStimulus("wrap", 32'h0000_0000, 1'b1, 1'b0, 1'b0);

        call = 1'b1; link = 32'h5000;
        applyStimulus("push5000", 32'h4, 1'b0, 1'b0, 1'b0);
        ret = 1'b1; redir = 1'b1; target = 32'h6000;
        applyStimulus("ret_redir", 32'h6000, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
